// File: rtl/cc_mux_rr_arbiter_if.sv
// Request/grant bus between the requesters and the round-robin mux arbiter.
// Signal names match the arbiter's external pin names.
interface cc_mux_rr_arbiter_if #(
    parameter int unsigned DATAWIDTH_MUX_SELECTION = 4,
    parameter int unsigned NUM_REQUESTERS          = 8
);
    logic [NUM_REQUESTERS-1:0]          CC_ARB_request_InBUS;
    logic [NUM_REQUESTERS-1:0]          CC_ARB_done_InBUS;
    logic [NUM_REQUESTERS-1:0]          CC_ARB_grant_OutBUS;
    logic [DATAWIDTH_MUX_SELECTION-1:0] CC_ARB_selection_OutBUS;
    logic                               CC_ARB_valid_Out;
    logic                               CC_ARB_timeout_Out;

    modport master (
        output CC_ARB_request_InBUS,
        output CC_ARB_done_InBUS,
        input  CC_ARB_grant_OutBUS,
        input  CC_ARB_selection_OutBUS,
        input  CC_ARB_valid_Out,
        input  CC_ARB_timeout_Out
    );

    modport slave (
        input  CC_ARB_request_InBUS,
        input  CC_ARB_done_InBUS,
        output CC_ARB_grant_OutBUS,
        output CC_ARB_selection_OutBUS,
        output CC_ARB_valid_Out,
        output CC_ARB_timeout_Out
    );
endinterface

// File: rtl/cc_mux_rr_arbiter.sv
// Round-robin arbiter for the shared 8-input bus multiplexer: one-hot grant,
// selection code with valid, and an optional per-grant hold timeout.
module cc_mux_rr_arbiter #(
    parameter int unsigned DATAWIDTH_MUX_SELECTION = 4,
    parameter int unsigned NUM_REQUESTERS          = 8,
    parameter int unsigned MAX_HOLD                = 16,
    parameter int unsigned HOLD_COUNTER_WIDTH      = 5
) (
    input  logic               CC_ARB_CLOCK_50,
    input  logic               CC_ARB_RESET_InHigh,
    cc_mux_rr_arbiter_if.slave arb_if
);
    localparam int unsigned PTR_W = 3;
    localparam logic [HOLD_COUNTER_WIDTH-1:0] HOLD_LAST = HOLD_COUNTER_WIDTH'(MAX_HOLD - 1);
    localparam logic [HOLD_COUNTER_WIDTH-1:0] CNT_ONE   = HOLD_COUNTER_WIDTH'(1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t                             state_q, state_d;
    logic [NUM_REQUESTERS-1:0]          grant_q, grant_d;
    logic [DATAWIDTH_MUX_SELECTION-1:0] sel_q, sel_d;
    logic                               valid_q, valid_d;
    logic                               timeout_q, timeout_d;
    logic [HOLD_COUNTER_WIDTH-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]                   last_q, last_d;

    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] scan_idx;
    logic             owner_done;
    logic             owner_req;
    logic             hold_expired;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        found     = 1'b0;
        win       = '0;
        scan_idx  = '0;

        // Circular scan beginning just after the last owner; the 3-bit add wraps mod 8.
        for (int unsigned i = 1; i <= 8; i++) begin
            scan_idx = last_q + PTR_W'(i);
            if (!found && arb_if.CC_ARB_request_InBUS[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end

        // While granted, last_q is the current owner.
        owner_done   = arb_if.CC_ARB_done_InBUS[last_q];
        owner_req    = arb_if.CC_ARB_request_InBUS[last_q];
        hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d      = ST_GRANT;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    sel_d        = DATAWIDTH_MUX_SELECTION'(win);
                    valid_d      = 1'b1;
                    last_d       = win;
                    cnt_d        = '0;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (owner_done || !owner_req || hold_expired) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    timeout_d = hold_expired && !owner_done && owner_req;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CC_ARB_CLOCK_50) begin
        if (CC_ARB_RESET_InHigh) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign arb_if.CC_ARB_grant_OutBUS     = grant_q;
    assign arb_if.CC_ARB_selection_OutBUS = sel_q;
    assign arb_if.CC_ARB_valid_Out        = valid_q;
    assign arb_if.CC_ARB_timeout_Out      = timeout_q;
endmodule

// File: tb/tb_cc_mux_rr_arbiter.sv
// Directed bench for cc_mux_rr_arbiter: reset, rotation, timeout, ignored
// non-owner bits, request drop and mid-grant reset.
module tb_cc_mux_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    cc_mux_rr_arbiter_if #(
        .DATAWIDTH_MUX_SELECTION(4),
        .NUM_REQUESTERS(8)
    ) bus ();

    cc_mux_rr_arbiter #(
        .DATAWIDTH_MUX_SELECTION(4),
        .NUM_REQUESTERS(8),
        .MAX_HOLD(16),
        .HOLD_COUNTER_WIDTH(5)
    ) dut (
        .CC_ARB_CLOCK_50(clk),
        .CC_ARB_RESET_InHigh(rst),
        .arb_if(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g, input logic [3:0] s,
                              input logic v, input logic t);
        chk({tag, ".grant"},   32'(bus.CC_ARB_grant_OutBUS),     32'(g));
        chk({tag, ".sel"},     32'(bus.CC_ARB_selection_OutBUS), 32'(s));
        chk({tag, ".valid"},   32'(bus.CC_ARB_valid_Out),        32'(v));
        chk({tag, ".timeout"}, 32'(bus.CC_ARB_timeout_Out),      32'(t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] eg;
        int         owner;

        rst = 1'b1;
        bus.CC_ARB_request_InBUS = 8'h00;
        bus.CC_ARB_done_InBUS    = 8'h00;
        step();
        step();
        expect_out("reset", 8'h00, 4'd0, 1'b0, 1'b0);

        // Single grant to 0, release by done
        rst = 1'b0;
        bus.CC_ARB_request_InBUS = 8'h01;
        step();
        expect_out("t1_grant", 8'h01, 4'd0, 1'b1, 1'b0);
        bus.CC_ARB_done_InBUS = 8'h01;
        step();
        expect_out("t1_release", 8'h00, 4'd0, 1'b0, 1'b0);
        bus.CC_ARB_done_InBUS    = 8'h00;
        bus.CC_ARB_request_InBUS = 8'h00;
        step();
        expect_out("t1_idle", 8'h00, 4'd0, 1'b0, 1'b0);

        // Full rotation 0..7 then wrap to 0, two-cycle grants
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.CC_ARB_request_InBUS = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            owner = k % 8;
            eg    = 8'h01 << owner;
            step();
            expect_out($sformatf("t2_g%0d_c1", k), eg, 4'(owner), 1'b1, 1'b0);
            step();
            expect_out($sformatf("t2_g%0d_c2", k), eg, 4'(owner), 1'b1, 1'b0);
            bus.CC_ARB_done_InBUS = eg;
            step();
            expect_out($sformatf("t2_g%0d_idle", k), 8'h00, 4'(owner), 1'b0, 1'b0);
            bus.CC_ARB_done_InBUS = 8'h00;
        end

        // Timeout after exactly 16 grant cycles
        rst = 1'b1;
        bus.CC_ARB_request_InBUS = 8'h08;
        step();
        rst = 1'b0;
        step();
        expect_out("t3_c1", 8'h08, 4'd3, 1'b1, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            step();
            expect_out($sformatf("t3_c%0d", c), 8'h08, 4'd3, 1'b1, 1'b0);
        end
        step();
        expect_out("t3_timeout", 8'h00, 4'd3, 1'b0, 1'b1);
        step();
        expect_out("t3_regrant", 8'h08, 4'd3, 1'b1, 1'b0);

        // Non-owner done ignored; done coincident with timeout suppresses pulse
        bus.CC_ARB_done_InBUS = 8'h20;
        step();
        expect_out("t4_nonowner_done", 8'h08, 4'd3, 1'b1, 1'b0);
        bus.CC_ARB_done_InBUS = 8'h00;
        for (int c = 3; c <= 16; c++) begin
            step();
            expect_out($sformatf("t4_c%0d", c), 8'h08, 4'd3, 1'b1, 1'b0);
        end
        bus.CC_ARB_done_InBUS = 8'h08;
        step();
        expect_out("t4_done_at_limit", 8'h00, 4'd3, 1'b0, 1'b0);
        bus.CC_ARB_done_InBUS    = 8'h00;
        bus.CC_ARB_request_InBUS = 8'h00;
        step();
        expect_out("t4_idle", 8'h00, 4'd3, 1'b0, 1'b0);

        // Owner 5 drops request; next grant scans 6,7,0
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.CC_ARB_request_InBUS = 8'h20;
        step();
        expect_out("t5_grant5", 8'h20, 4'd5, 1'b1, 1'b0);
        bus.CC_ARB_request_InBUS = 8'h21;
        step();
        expect_out("t5_hold5", 8'h20, 4'd5, 1'b1, 1'b0);
        bus.CC_ARB_request_InBUS = 8'h01;
        step();
        expect_out("t5_release", 8'h00, 4'd5, 1'b0, 1'b0);
        step();
        expect_out("t5_grant0", 8'h01, 4'd0, 1'b1, 1'b0);

        // Reset during a grant to 6 restores pointer 7
        bus.CC_ARB_request_InBUS = 8'h00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.CC_ARB_request_InBUS = 8'hC0;
        step();
        expect_out("t6_grant6", 8'h40, 4'd6, 1'b1, 1'b0);
        step();
        expect_out("t6_hold6", 8'h40, 4'd6, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        expect_out("t6_reset", 8'h00, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expect_out("t6_after_reset", 8'h40, 4'd6, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
